// File: rtl/flush_fifo_pkg.sv
// Shared helpers for the flush FIFO.
// Holds the width helper used for pointer and count sizing.
package flush_fifo_pkg;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) begin
      r++;
    end
    if (r == 0) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/flush_fifo_reg.sv
// Generic register with synchronous active-high clear and write enable.
// Used for FIFO entries, pointers and occupancy count.
module flush_fifo_reg #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (we) begin
      q <= d;
    end
  end

endmodule

// File: rtl/flush_fifo.sv
// Synchronous FIFO with single-cycle flush and optional fall-through.
// Occupancy count register is the sole source of full/empty/almost-full.
module flush_fifo
  import flush_fifo_pkg::*;
#(
  parameter  int DATA_WIDTH   = 32,
  parameter  int FIFO_DEPTH   = 8,
  parameter  int AFULL_THRESH = FIFO_DEPTH - 1,
  parameter  int FALL_THROUGH = 0,
  localparam int ADDR_WIDTH   = clog2(FIFO_DEPTH),
  localparam int CNT_WIDTH    = clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_i,
  input  logic                  valid_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  ready_o,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  ready_i,
  output logic [CNT_WIDTH-1:0]  count_o,
  output logic                  almost_full_o
);

  function automatic logic [ADDR_WIDTH-1:0] inc_wrap(
    input logic [ADDR_WIDTH-1:0] p
  );
    return (p == ADDR_WIDTH'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
  logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic full, empty, bypass;
  logic enq, deq, bp_xfer, wr, rd;

  assign full    = (cnt_q == CNT_WIDTH'(FIFO_DEPTH));
  assign empty   = (cnt_q == '0);
  assign bypass  = (FALL_THROUGH != 0) && empty;

  assign ready_o = !full && !flush_i;
  assign valid_o = bypass ? (valid_i && !flush_i)
                          : (!empty && !flush_i);
  assign data_o  = bypass ? data_i : mem_q[rptr_q];

  assign enq     = ready_o && valid_i;
  assign deq     = ready_i && valid_o;
  // A bypassed word never touches storage.
  assign bp_xfer = bypass && enq && deq;
  assign wr      = enq && !bp_xfer;
  assign rd      = deq && !bp_xfer;

  assign count_o       = cnt_q;
  assign almost_full_o = (cnt_q >= CNT_WIDTH'(AFULL_THRESH));

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (flush_i) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (wr) wptr_d = inc_wrap(wptr_q);
      if (rd) rptr_d = inc_wrap(rptr_q);
      case ({wr, rd})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  flush_fifo_reg #(.WIDTH(ADDR_WIDTH)) u_wptr (
    .clk(clk), .rst(rst), .we(1'b1), .d(wptr_d), .q(wptr_q)
  );

  flush_fifo_reg #(.WIDTH(ADDR_WIDTH)) u_rptr (
    .clk(clk), .rst(rst), .we(1'b1), .d(rptr_d), .q(rptr_q)
  );

  flush_fifo_reg #(.WIDTH(CNT_WIDTH)) u_cnt (
    .clk(clk), .rst(rst), .we(1'b1), .d(cnt_d), .q(cnt_q)
  );

  for (genvar i = 0; i < FIFO_DEPTH; i++) begin : g_ent
    logic ent_we;
    assign ent_we = wr && !flush_i &&
                    (wptr_q == ADDR_WIDTH'(i));
    flush_fifo_reg #(.WIDTH(DATA_WIDTH)) u_ent (
      .clk(clk),
      .rst(1'b0),
      .we(ent_we),
      .d(data_i),
      .q(mem_q[i])
    );
  end

endmodule

// File: tb/tb_flush_fifo.sv
// Bench for flush_fifo: three configurations driven against
// a queue-based reference model plus directed scenarios.
module tb_flush_fifo;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        vi [3];
  logic [31:0] di [3];
  logic        ri [3];
  logic        fl [3];
  logic        ro [3];
  logic        vo [3];
  logic [31:0] dq [3];
  logic        af [3];
  logic [3:0]  cnt8;
  logic [2:0]  cnt5;
  logic [3:0]  cntf;

  int DEP  [3] = '{8, 5, 8};
  int TH   [3] = '{7, 4, 7};
  int MODE [3] = '{0, 0, 1};

  logic [31:0] mq [3][$];

  int checks = 0;
  int errors = 0;

  logic        obs_ready, obs_valid;
  logic [31:0] obs_data;

  flush_fifo #(.DATA_WIDTH(32), .FIFO_DEPTH(8)) u8 (
    .clk(clk), .rst(rst), .flush_i(fl[0]),
    .valid_i(vi[0]), .data_i(di[0]), .ready_o(ro[0]),
    .valid_o(vo[0]), .data_o(dq[0]), .ready_i(ri[0]),
    .count_o(cnt8), .almost_full_o(af[0])
  );

  flush_fifo #(.DATA_WIDTH(32), .FIFO_DEPTH(5)) u5 (
    .clk(clk), .rst(rst), .flush_i(fl[1]),
    .valid_i(vi[1]), .data_i(di[1]), .ready_o(ro[1]),
    .valid_o(vo[1]), .data_o(dq[1]), .ready_i(ri[1]),
    .count_o(cnt5), .almost_full_o(af[1])
  );

  flush_fifo #(.DATA_WIDTH(32), .FIFO_DEPTH(8),
               .FALL_THROUGH(1)) uft (
    .clk(clk), .rst(rst), .flush_i(fl[2]),
    .valid_i(vi[2]), .data_i(di[2]), .ready_o(ro[2]),
    .valid_o(vo[2]), .data_o(dq[2]), .ready_i(ri[2]),
    .count_o(cntf), .almost_full_o(af[2])
  );

  function automatic int cnt_of(int k);
    case (k)
      0:       return int'(cnt8);
      1:       return int'(cnt5);
      default: return int'(cntf);
    endcase
  endfunction

  task automatic idle_all();
    for (int j = 0; j < 3; j++) begin
      vi[j] = 1'b0; ri[j] = 1'b0; fl[j] = 1'b0; di[j] = '0;
    end
  endtask

  // One clock of stimulus on instance k, checked against the model.
  task automatic cyc(int k, bit v, logic [31:0] d, bit r, bit f);
    int n;
    bit er, ev, bp, eaf, enq, deq;
    logic [31:0] ed;
    @(negedge clk);
    idle_all();
    vi[k] = v; di[k] = d; ri[k] = r; fl[k] = f;
    #1;
    n   = mq[k].size();
    bp  = (MODE[k] != 0) && (n == 0);
    er  = (n < DEP[k]) && !f;
    ev  = bp ? (v && !f) : ((n > 0) && !f);
    ed  = bp ? d : ((n > 0) ? mq[k][0] : 32'h0);
    eaf = (n >= TH[k]);
    obs_ready = ro[k]; obs_valid = vo[k]; obs_data = dq[k];
    checks++;
    if (ro[k] !== er) begin
      errors++;
      $display("FAIL ready_o[%0d] got %b exp %b", k, ro[k], er);
    end
    checks++;
    if (vo[k] !== ev) begin
      errors++;
      $display("FAIL valid_o[%0d] got %b exp %b", k, vo[k], ev);
    end
    if (ev) begin
      checks++;
      if (dq[k] !== ed) begin
        errors++;
        $display("FAIL data_o[%0d] got %h exp %h", k, dq[k], ed);
      end
    end
    checks++;
    if (cnt_of(k) != n) begin
      errors++;
      $display("FAIL count_o[%0d] got %0d exp %0d", k, cnt_of(k), n);
    end
    checks++;
    if (af[k] !== eaf) begin
      errors++;
      $display("FAIL almost_full_o[%0d] got %b exp %b", k, af[k], eaf);
    end
    if (f) begin
      mq[k].delete();
    end else begin
      enq = er && v;
      deq = r && ev;
      if (!(bp && enq && deq)) begin
        if (deq) void'(mq[k].pop_front());
        if (enq) mq[k].push_back(d);
      end
    end
    @(posedge clk);
  endtask

  task automatic drain(int k);
    for (int i = 0; i < 20 && mq[k].size() > 0; i++)
      cyc(k, 0, 32'h0, 1, 0);
  endtask

  task automatic do_rst();
    @(negedge clk);
    idle_all();
    rst = 1'b1;
    @(posedge clk);
    for (int j = 0; j < 3; j++) mq[j].delete();
    #1;
  endtask

  task automatic test_reset();
    do_rst();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (ro[k] !== 1'b1 || vo[k] !== 1'b0 ||
          cnt_of(k) != 0 || af[k] !== 1'b0) begin
        errors++;
        $display("FAIL reset[%0d] got rdy=%b vld=%b cnt=%0d af=%b exp 1 0 0 0",
                 k, ro[k], vo[k], cnt_of(k), af[k]);
      end
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 8; i++)
      cyc(0, 1, 32'h11 * (i + 1), 0, 0);
    #1;
    checks++;
    if (ro[0] !== 1'b0 || cnt8 !== 4'd8 || af[0] !== 1'b1) begin
      errors++;
      $display("FAIL full_state got rdy=%b cnt=%0d af=%b exp 0 8 1",
               ro[0], cnt8, af[0]);
    end
    for (int i = 0; i < 8; i++) begin
      cyc(0, 0, 32'h0, 1, 0);
      checks++;
      if (obs_data !== 32'h11 * (i + 1)) begin
        errors++;
        $display("FAIL drain_order got %h exp %h",
                 obs_data, 32'h11 * (i + 1));
      end
    end
    #1;
    checks++;
    if (cnt8 !== 4'd0) begin
      errors++;
      $display("FAIL drain_empty got %0d exp 0", cnt8);
    end
  endtask

  task automatic test_wrap();
    cyc(1, 1, $urandom, 1, 0);
    for (int i = 0; i < 12; i++) begin
      cyc(1, 1, $urandom, 1, 0);
      #1;
      checks++;
      if (cnt5 !== 3'd1) begin
        errors++;
        $display("FAIL wrap_count got %0d exp 1", cnt5);
      end
    end
    drain(1);
  endtask

  task automatic test_bypass();
    cyc(2, 1, 32'hAB, 1, 0);
    checks++;
    if (obs_valid !== 1'b1 || obs_data !== 32'hAB) begin
      errors++;
      $display("FAIL bypass got vld=%b data=%h exp 1 ab",
               obs_valid, obs_data);
    end
    #1;
    checks++;
    if (cntf !== 4'd0) begin
      errors++;
      $display("FAIL bypass_count got %0d exp 0", cntf);
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) cyc(0, 1, $urandom, 0, 0);
    cyc(0, 1, 32'hDEAD, 1, 1);
    checks++;
    if (obs_ready !== 1'b0 || obs_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_hs got rdy=%b vld=%b exp 0 0",
               obs_ready, obs_valid);
    end
    #1;
    checks++;
    if (cnt8 !== 4'd0) begin
      errors++;
      $display("FAIL flush_count got %0d exp 0", cnt8);
    end
  endtask

  task automatic test_full_simul();
    for (int i = 0; i < 8; i++) cyc(0, 1, $urandom, 0, 0);
    cyc(0, 1, 32'h5555, 1, 0);
    checks++;
    if (obs_ready !== 1'b0 || obs_valid !== 1'b1) begin
      errors++;
      $display("FAIL full_hs got rdy=%b vld=%b exp 0 1",
               obs_ready, obs_valid);
    end
    #1;
    checks++;
    if (cnt8 !== 4'd7) begin
      errors++;
      $display("FAIL full_deq_count got %0d exp 7", cnt8);
    end
    cyc(0, 1, 32'h6666, 0, 0);
    checks++;
    if (obs_ready !== 1'b1) begin
      errors++;
      $display("FAIL full_reenq got rdy=%b exp 1", obs_ready);
    end
    drain(0);
  endtask

  task automatic test_rst_mid();
    for (int i = 0; i < 4; i++) cyc(0, 1, $urandom, 0, 0);
    do_rst();
    checks++;
    if (cnt8 !== 4'd0 || ro[0] !== 1'b1 || vo[0] !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid got cnt=%0d rdy=%b vld=%b exp 0 1 0",
               cnt8, ro[0], vo[0]);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_random();
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 400; i++) begin
        cyc(k, 1'($urandom_range(0, 1)), $urandom,
            1'($urandom_range(0, 2) != 0),
            ($urandom_range(0, 29) == 0));
      end
      drain(k);
    end
  endtask

  initial begin
    idle_all();
    test_reset();
    test_fill_drain();
    test_wrap();
    test_bypass();
    test_flush();
    test_full_simul();
    test_rst_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
